// File: rtl/cv32e40s_rvfi_obi_instr_tracker.sv
// ----------------------------------------------------------------------------
// cv32e40s_rvfi_obi_instr_tracker
//
// Purpose:
//   Trace-side monitor on the instruction OBI bus. Each granted request
//   payload is queued in a small in-order FIFO. When the matching rvalid
//   arrives, the queued payload is paired with the response payload, and the
//   pair is emitted as one rvfi_obi_instr_t record for retirement tracing.
//   The block only observes the bus. It never drives it.
//
// Parameters:
//   DEPTH           max outstanding granted requests tracked (>=1)
//   TIMEOUT_CYCLES  response-timeout threshold (used only with the macro below)
//
// Optional feature:
//   `define CV32E40S_RVFI_OBI_TIMEOUT_EN builds the response-timeout counter.
//   If the macro is not defined, timeout_o is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   obi_req_i, obi_gnt_i     request handshake; payload captured on req&&gnt
//   obi_req_payload_i        addr/prot/memtype/dbg of the request
//   obi_rvalid_i             response valid
//   obi_resp_payload_i       rdata/err of the response
//   rvfi_obi_instr_o         last paired {request, response} record
//   rvfi_obi_instr_valid_o   1-cycle pulse when a new record is present
//   outstanding_o            granted-but-unanswered count
//   err_underflow_o          sticky: rvalid with nothing outstanding
//   err_overflow_o           sticky: grant dropped because the FIFO was full
//   timeout_o                sticky: oldest request waited TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
package cv32e40s_rvfi_obi_instr_tracker_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [1:0]  memtype;
        logic        dbg;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    typedef struct packed {
        obi_inst_req_t  req_payload;
        obi_inst_resp_t resp_payload;
    } rvfi_obi_instr_t;

endpackage

module cv32e40s_rvfi_obi_instr_tracker
    import cv32e40s_rvfi_obi_instr_tracker_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         obi_req_i,
    input  logic                         obi_gnt_i,
    input  obi_inst_req_t                obi_req_payload_i,
    input  logic                         obi_rvalid_i,
    input  obi_inst_resp_t               obi_resp_payload_i,
    output rvfi_obi_instr_t              rvfi_obi_instr_o,
    output logic                         rvfi_obi_instr_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         err_underflow_o,
    output logic                         err_overflow_o,
    output logic                         timeout_o
);

    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 1) begin : g_depth_chk
        $error("DEPTH must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    obi_inst_req_t    mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic push_ok;
    logic pop_ok;
    logic empty;
    logic full;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push    = obi_req_i && obi_gnt_i;
    // An rvalid cannot complete a same-cycle grant, so a pop needs an entry
    // that was already stored before this edge.
    assign pop_ok  = obi_rvalid_i && !empty;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Payload storage is not reset. Entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= obi_req_payload_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr                   <= '0;
            rptr                   <= '0;
            count                  <= '0;
            rvfi_obi_instr_o       <= '0;
            rvfi_obi_instr_valid_o <= 1'b0;
            err_underflow_o        <= 1'b0;
            err_overflow_o         <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr                          <= (rptr == LAST_PTR) ? '0 : rptr + PTR_W'(1);
                rvfi_obi_instr_o.req_payload  <= mem[rptr];
                rvfi_obi_instr_o.resp_payload <= obi_resp_payload_i;
            end
            rvfi_obi_instr_valid_o <= pop_ok;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);

            if (obi_rvalid_i && empty) begin
                err_underflow_o <= 1'b1;
            end
            if (push && full && !pop_ok) begin
                err_overflow_o <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;

`ifdef CV32E40S_RVFI_OBI_TIMEOUT_EN
    localparam int unsigned      TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // The counter measures how long the oldest entry has waited. It restarts
    // on every pop, stays at 0 while the FIFO is empty, and saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (pop_ok || empty) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (to_cnt == TO_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_rvfi_obi_instr_tracker.sv
// ----------------------------------------------------------------------------
// tb_cv32e40s_rvfi_obi_instr_tracker
//
// Self-checking bench for the OBI instruction tracker.
//
// Directed scenarios check the outputs against constant expectations:
//   reset, single fetch, back-to-back fetches, error cases, reset while
//   requests are in flight, and timeout.
// A randomized phase checks every output against a queue-based reference
// model on every cycle.
// ----------------------------------------------------------------------------
module tb_cv32e40s_rvfi_obi_instr_tracker;
    import cv32e40s_rvfi_obi_instr_tracker_pkg::*;

    localparam int unsigned DEPTH          = 2;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int unsigned CNT_W          = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             obi_req;
    logic             obi_gnt;
    obi_inst_req_t    req_pl;
    logic             obi_rvalid;
    obi_inst_resp_t   resp_pl;
    rvfi_obi_instr_t  rec;
    logic             rec_valid;
    logic [CNT_W-1:0] outstanding;
    logic             uf;
    logic             of;
    logic             tmo;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of granted payloads plus the last emitted record.
    obi_inst_req_t   mq[$];
    rvfi_obi_instr_t m_rec;
    bit              m_valid;
    bit              m_uf;
    bit              m_of;

    always #5 clk = ~clk;

    cv32e40s_rvfi_obi_instr_tracker #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .obi_req_i              (obi_req),
        .obi_gnt_i              (obi_gnt),
        .obi_req_payload_i      (req_pl),
        .obi_rvalid_i           (obi_rvalid),
        .obi_resp_payload_i     (resp_pl),
        .rvfi_obi_instr_o       (rec),
        .rvfi_obi_instr_valid_o (rec_valid),
        .outstanding_o          (outstanding),
        .err_underflow_o        (uf),
        .err_overflow_o         (of),
        .timeout_o              (tmo)
    );

    // Applies one cycle of stimulus at the negedge and updates the model at the
    // posedge. It returns #1 after the edge so that callers can sample outputs.
    task automatic drive_cycle(input bit r, input bit rq, input bit gn, input bit rv,
                               input logic [31:0] addr, input logic [31:0] rdata,
                               input bit err);
        @(negedge clk);
        rst             = r;
        obi_req         = rq;
        obi_gnt         = gn;
        req_pl.addr     = addr;
        req_pl.prot     = 3'($urandom);
        req_pl.memtype  = 2'($urandom);
        req_pl.dbg      = 1'($urandom);
        obi_rvalid      = rv;
        resp_pl.rdata   = rdata;
        resp_pl.err     = err;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_rec   = '0;
            m_valid = 0;
            m_uf    = 0;
            m_of    = 0;
        end else begin
            m_valid = 0;
            if (rv) begin
                if (mq.size() == 0) begin
                    m_uf = 1;
                end else begin
                    m_rec.req_payload  = mq.pop_front();
                    m_rec.resp_payload = resp_pl;
                    m_valid            = 1;
                end
            end
            if (rq && gn) begin
                if (mq.size() < DEPTH) mq.push_back(req_pl);
                else                   m_of = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_reset();
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        idle(1);
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rec_valid); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (rec !== '0) begin errors++; $display("FAIL reset_record got=%h exp=0", rec); end
        checks++; if ({uf, of, tmo} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {uf, of, tmo}); end
    endtask

    task automatic test_single();
        drive_cycle(0, 1, 1, 0, 32'h0000_0080, 32'h0, 0);
        checks++; if (outstanding !== CNT_W'(1)) begin errors++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h0000_0013, 0);
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rec_valid); end
        checks++; if (rec.req_payload.addr !== 32'h80) begin errors++; $display("FAIL single_addr got=%h exp=80", rec.req_payload.addr); end
        checks++; if (rec.resp_payload.rdata !== 32'h13 || rec.resp_payload.err !== 1'b0) begin errors++; $display("FAIL single_resp got=%h/%b exp=13/0", rec.resp_payload.rdata, rec.resp_payload.err); end
        idle(1);
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", rec_valid); end
        checks++; if (rec.req_payload.addr !== 32'h80) begin errors++; $display("FAIL single_hold got=%h exp=80", rec.req_payload.addr); end
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, 1, 1, 0, 32'h100, 32'h0, 0);
        drive_cycle(0, 1, 1, 0, 32'h104, 32'h0, 0);
        checks++; if (outstanding !== CNT_W'(2)) begin errors++; $display("FAIL b2b_full got=%0d exp=2", outstanding); end
        drive_cycle(0, 1, 1, 1, 32'h108, 32'hAAAA_0000, 0);
        checks++; if (rec_valid !== 1'b1 || rec.req_payload.addr !== 32'h100 || rec.resp_payload.rdata !== 32'hAAAA_0000)
            begin errors++; $display("FAIL b2b_rec0 got=%b/%h/%h exp=1/100/aaaa0000", rec_valid, rec.req_payload.addr, rec.resp_payload.rdata); end
        checks++; if (outstanding !== CNT_W'(2) || of !== 1'b0) begin errors++; $display("FAIL b2b_pushpop got=%0d/%b exp=2/0", outstanding, of); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'hAAAA_0001, 0);
        checks++; if (rec_valid !== 1'b1 || rec.req_payload.addr !== 32'h104) begin errors++; $display("FAIL b2b_rec1 got=%b/%h exp=1/104", rec_valid, rec.req_payload.addr); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'hAAAA_0002, 1);
        checks++; if (rec_valid !== 1'b1 || rec.req_payload.addr !== 32'h108 || rec.resp_payload.err !== 1'b1)
            begin errors++; $display("FAIL b2b_rec2 got=%b/%h/%b exp=1/108/1", rec_valid, rec.req_payload.addr, rec.resp_payload.err); end
        checks++; if (outstanding !== '0 || uf !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0d/%b exp=0/0", outstanding, uf); end
    endtask

    task automatic test_errors();
        drive_cycle(0, 0, 0, 1, 32'h0, 32'hDEAD_0000, 0);
        checks++; if (uf !== 1'b1 || rec_valid !== 1'b0) begin errors++; $display("FAIL underflow got=%b/%b exp=1/0", uf, rec_valid); end
        drive_cycle(0, 1, 1, 0, 32'h300, 32'h0, 0);
        drive_cycle(0, 1, 1, 0, 32'h304, 32'h0, 0);
        drive_cycle(0, 1, 1, 0, 32'h308, 32'h0, 0);
        checks++; if (of !== 1'b1 || outstanding !== CNT_W'(2)) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/2", of, outstanding); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h1, 0);
        checks++; if (rec.req_payload.addr !== 32'h300) begin errors++; $display("FAIL ovf_rec0 got=%h exp=300", rec.req_payload.addr); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h2, 0);
        checks++; if (rec.req_payload.addr !== 32'h304) begin errors++; $display("FAIL ovf_rec1 got=%h exp=304", rec.req_payload.addr); end
        // Push into an empty FIFO with a same-cycle rvalid: push kept, no record.
        drive_cycle(0, 1, 1, 1, 32'h30C, 32'h3, 0);
        checks++; if (rec_valid !== 1'b0 || outstanding !== CNT_W'(1)) begin errors++; $display("FAIL push_empty_rv got=%b/%0d exp=0/1", rec_valid, outstanding); end
        idle(1);
        checks++; if (uf !== 1'b1 || of !== 1'b1) begin errors++; $display("FAIL sticky got=%b%b exp=11", uf, of); end
    endtask

    task automatic test_reset_midflight();
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        drive_cycle(0, 1, 1, 0, 32'h200, 32'h0, 0);
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (outstanding !== '0 || uf !== 1'b0) begin errors++; $display("FAIL midrst_clear got=%0d/%b exp=0/0", outstanding, uf); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h55, 0);
        checks++; if (rec_valid !== 1'b0 || outstanding !== '0 || uf !== 1'b1)
            begin errors++; $display("FAIL midrst_rv got=%b/%0d/%b exp=0/0/1", rec_valid, outstanding, uf); end
    endtask

    task automatic test_random();
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 400; i++) begin
            drive_cycle(0, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 70),
                        ($urandom_range(0, 99) < 45), $urandom, $urandom, 1'($urandom));
            checks++;
            if (rec_valid !== m_valid || rec !== m_rec || outstanding !== CNT_W'(mq.size())
                || uf !== m_uf || of !== m_of) begin
                errors++;
                $display("FAIL random[%0d] got v=%b rec=%h n=%0d uf=%b of=%b exp v=%b rec=%h n=%0d uf=%b of=%b",
                         i, rec_valid, rec, outstanding, uf, of, m_valid, m_rec, mq.size(), m_uf, m_of);
            end
`ifndef CV32E40S_RVFI_OBI_TIMEOUT_EN
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL random_timeout got=%b exp=0", tmo); end
`endif
        end
    endtask

    task automatic test_timeout();
        bit exp_tmo;
`ifdef CV32E40S_RVFI_OBI_TIMEOUT_EN
        exp_tmo = 1;
`else
        exp_tmo = 0;
`endif
        drive_cycle(1, 0, 0, 0, 32'h0, 32'h0, 0);
        drive_cycle(0, 1, 1, 0, 32'h400, 32'h0, 0);
        idle(3);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", tmo); end
        idle(TIMEOUT_CYCLES + 2);
        checks++; if (tmo !== exp_tmo) begin errors++; $display("FAIL timeout_set got=%b exp=%b", tmo, exp_tmo); end
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h0, 0);
        idle(3);
        checks++; if (tmo !== exp_tmo) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", tmo, exp_tmo); end
    endtask

    initial begin
        rst        = 1'b1;
        obi_req    = 1'b0;
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        req_pl     = '0;
        resp_pl    = '0;
        m_rec      = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_reset_midflight();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
